// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types for the pipeline hazard unit:
//   fwdSel_t   - E-stage operand select encodings (register file / WB / MEM)
//   memState_t - states of the data-memory wait FSM
//   fwdSelect  - forwarding priority rule for one E-stage source operand
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // operand comes from the register file
    FWD_WB  = 2'b01,  // operand comes from ResultW
    FWD_MEM = 2'b10   // operand comes from ALUOutM
  } fwdSel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    ABORT = 2'b10
  } memState_t;

  // The M stage holds the younger result, so it wins over W. Register 0 is
  // hard-wired to zero and must never be forwarded.
  function automatic fwdSel_t fwdSelect(input logic [4:0] src,
                                        input logic       regwriteM,
                                        input logic [4:0] writeregM,
                                        input logic       regwriteW,
                                        input logic [4:0] writeregW);
    fwdSel_t sel;
    sel = FWD_RF;
    if (src != 5'd0 && regwriteM && src == writeregM)
      sel = FWD_MEM;
    else if (src != 5'd0 && regwriteW && src == writeregW)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that increments by one while en is high and holds at all-ones.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears the count
//   en    - count this cycle
//   count - current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (en && count != '1)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard detection and forwarding for a 5-stage MIPS-style core,
// extended with a data-memory wait FSM that aborts an access after TIMEOUT
// stall cycles and reports it on a sticky error flag.
// Ports:
//   clk, reset                   - clock, asynchronous active-low reset
//   rsD, rtD, rsE, rtE           - source register numbers (D, E stages)
//   writeregE/M/W                - destination register numbers
//   regwriteE/M/W, memtoregE/M,
//   memwriteM, branchD, jumpD,
//   pcsrcD                       - stage control bits
//   dmem_ready                   - data memory finished the access in M
//   stallF/D/E/M                 - hold pipeline registers
//   flushD/E/W                   - bubble pipeline registers
//   forwardAD/BD                 - branch comparator takes ALUOutM
//   forwardAE/BE                 - E operand select (fwdSel_t encoding)
//   mem_err                      - sticky: a memory access timed out
//   stall_cnt, flush_cnt         - saturating performance counters
// ---------------------------------------------------------------------------
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             memwriteM,
  input  logic             branchD,
  input  logic             jumpD,
  input  logic             pcsrcD,
  input  logic             dmem_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The wait count must reach TIMEOUT-1; it never runs past that in WAIT.
  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT - 1) : 1;
  // The FSM leaves WAIT on the cycle whose increment would make the count
  // TIMEOUT-1, so the access is stalled for exactly TIMEOUT cycles in total
  // (one in IDLE plus TIMEOUT-1 in WAIT).
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 2);

  memState_t         state;
  logic [WAIT_W-1:0] waitCnt;
  logic              memErr;

  logic    lwStall, branchStall, memStall, frontStall;
  fwdSel_t fwdA, fwdB;

  // ---- raw hazard terms ---------------------------------------------------
  assign lwStall     = memtoregE && (rtE == rsD || rtE == rtD);
  assign branchStall = branchD &&
                       ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                        (memtoregM && (writeregM == rsD || writeregM == rtD)));
  // In ABORT the pending access is dropped, letting the pipeline move on.
  assign memStall    = (memtoregM || memwriteM) && !dmem_ready && (state != ABORT);
  assign frontStall  = lwStall || branchStall || memStall;

  assign fwdA = fwdSelect(rsE, regwriteM, writeregM, regwriteW, writeregW);
  assign fwdB = fwdSelect(rtE, regwriteM, writeregM, regwriteW, writeregW);

  // ---- outputs ------------------------------------------------------------
  // NOTE: the combinational outputs are gated by reset so the pipeline sees
  // no stall, flush or forward while reset is held, whatever the inputs do.
  assign stallF    = reset && frontStall;
  assign stallD    = reset && frontStall;
  assign stallE    = reset && memStall;
  assign stallM    = reset && memStall;
  // A memory stall freezes E, so a load-use bubble must not be injected then.
  assign flushE    = reset && (lwStall || branchStall) && !memStall;
  assign flushW    = reset && memStall;
  // A held D stage keeps its instruction; flushing it would lose it.
  assign flushD    = reset && (pcsrcD || jumpD) && !frontStall;
  assign forwardAD = reset && rsD != 5'd0 && regwriteM && rsD == writeregM;
  assign forwardBD = reset && rtD != 5'd0 && regwriteM && rtD == writeregM;
  assign forwardAE = reset ? fwdA : FWD_RF;
  assign forwardBE = reset ? fwdB : FWD_RF;
  assign mem_err   = memErr;

  // ---- data-memory wait FSM -----------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memStall) begin
            state   <= WAIT;
            waitCnt <= '0;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt + 1'b1;
          if (dmem_ready) begin
            state <= IDLE;
          end else if (waitCnt == LAST_WAIT) begin
            state  <= ABORT;
            memErr <= 1'b1;
          end
        end
        ABORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- performance counters -----------------------------------------------
  // flushD and flushE are mutually exclusive by construction, but the OR
  // also guarantees a single increment if both were ever high together.
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (stallF),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (flushD || flushE),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
// Directed scenarios followed by random stimulus, each cycle compared with a
// behavioural model that tracks the memory wait as a count of consecutive
// stalled cycles and the counters as saturating integers.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       memwriteM, branchD, jumpD, pcsrcD, dmem_ready;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic       forwardAD, forwardBD, mem_err;
  logic [1:0] forwardAE, forwardBE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .memwriteM(memwriteM),
    .branchD(branchD), .jumpD(jumpD), .pcsrcD(pcsrcD), .dmem_ready(dmem_ready),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int mWait;    // consecutive stalled cycles of the current access
  bit mAbort;   // this cycle is the one-cycle abort window
  bit mErr;
  int mStall;
  int mFlush;
  bit mLastMs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mWait = 0; mAbort = 0; mErr = 0; mStall = 0; mFlush = 0; mLastMs = 0;
  endtask

  task automatic idle();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; memwriteM = 0;
    branchD = 0; jumpD = 0; pcsrcD = 0; dmem_ready = 1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".stallF"}, 32'(stallF), 0);
    check({tag, ".stallD"}, 32'(stallD), 0);
    check({tag, ".stallE"}, 32'(stallE), 0);
    check({tag, ".stallM"}, 32'(stallM), 0);
    check({tag, ".flushD"}, 32'(flushD), 0);
    check({tag, ".flushE"}, 32'(flushE), 0);
    check({tag, ".flushW"}, 32'(flushW), 0);
    check({tag, ".fwdAD"},  32'(forwardAD), 0);
    check({tag, ".fwdBD"},  32'(forwardBD), 0);
    check({tag, ".fwdAE"},  32'(forwardAE), 0);
    check({tag, ".fwdBE"},  32'(forwardBE), 0);
    check({tag, ".memErr"}, 32'(mem_err), 0);
    check({tag, ".stallCnt"}, 32'(stall_cnt), 0);
    check({tag, ".flushCnt"}, 32'(flush_cnt), 0);
  endtask

  function automatic logic [1:0] expFwdE(input logic [4:0] r);
    if (r != 0 && regwriteM && r == writeregM) return 2'b10;
    if (r != 0 && regwriteW && r == writeregW) return 2'b01;
    return 2'b00;
  endfunction

  // Check one clock cycle against the model, then advance to just after the
  // next rising edge. Inputs must already be applied by the caller.
  task automatic cycle(input string tag);
    bit lw, br, ms, sFD, fE, fD;
    #1;
    lw  = memtoregE && (rtE == rsD || rtE == rtD);
    br  = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                      (memtoregM && (writeregM == rsD || writeregM == rtD)));
    ms  = (memtoregM || memwriteM) && !dmem_ready && !mAbort;
    sFD = lw || br || ms;
    fE  = (lw || br) && !ms;
    fD  = (pcsrcD || jumpD) && !sFD;
    check({tag, ".stallF"}, 32'(stallF), 32'(sFD));
    check({tag, ".stallD"}, 32'(stallD), 32'(sFD));
    check({tag, ".stallE"}, 32'(stallE), 32'(ms));
    check({tag, ".stallM"}, 32'(stallM), 32'(ms));
    check({tag, ".flushD"}, 32'(flushD), 32'(fD));
    check({tag, ".flushE"}, 32'(flushE), 32'(fE));
    check({tag, ".flushW"}, 32'(flushW), 32'(ms));
    check({tag, ".fwdAD"},  32'(forwardAD), 32'(rsD != 0 && regwriteM && rsD == writeregM));
    check({tag, ".fwdBD"},  32'(forwardBD), 32'(rtD != 0 && regwriteM && rtD == writeregM));
    check({tag, ".fwdAE"},  32'(forwardAE), 32'(expFwdE(rsE)));
    check({tag, ".fwdBE"},  32'(forwardBE), 32'(expFwdE(rtE)));
    check({tag, ".memErr"}, 32'(mem_err), 32'(mErr));
    check({tag, ".stallCnt"}, 32'(stall_cnt), 32'(mStall));
    check({tag, ".flushCnt"}, 32'(flush_cnt), 32'(mFlush));
    if (mAbort) begin
      mAbort = 0;
      mWait  = 0;
    end else if (ms) begin
      mWait++;
      if (mWait == TIMEOUT) begin
        mAbort = 1;
        mErr   = 1;
      end
    end else begin
      mWait = 0;
    end
    if (sFD && mStall < SAT) mStall++;
    if ((fD || fE) && mFlush < SAT) mFlush++;
    mLastMs = ms;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    resetModel();

    // Reset held with hazards on every input: everything must read zero.
    reset = 1'b0;
    idle();
    memtoregE = 1; rtE = 8; rsD = 8; memwriteM = 1; dmem_ready = 0;
    regwriteM = 1; writeregM = 8; rsE = 8; jumpD = 1;
    #1 checkAllZero("rst");
    @(posedge clk); #1;
    checkAllZero("rstEdge");
    reset = 1'b1;
    resetModel();

    // E-stage forwarding priority and register-0 exclusion.
    idle();
    rsE = 5; rtE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
    #1 check("fwdMem", 32'(forwardAE), 32'h2);
    regwriteM = 0;
    #1 check("fwdWb", 32'(forwardBE), 32'h1);
    regwriteM = 1; rsE = 0;
    #1 check("fwdZero", 32'(forwardAE), 32'h0);
    cycle("fwd");

    // Load-use stall for one cycle.
    idle();
    memtoregE = 1; rtE = 8; rsD = 8;
    s0 = mStall;
    #1 check("lw.stallF", 32'(stallF), 1);
    check("lw.stallD", 32'(stallD), 1);
    check("lw.flushE", 32'(flushE), 1);
    cycle("lw");
    idle();
    #1 check("lw.cntInc", 32'(stall_cnt), 32'(s0 + 1));
    check("lw.released", 32'(stallF), 0);
    cycle("lwAfter");

    // Branch on a register written by E: stall wins over redirect flush.
    idle();
    branchD = 1; regwriteE = 1; writeregE = 3; rtD = 3; pcsrcD = 1;
    #1 check("br.stallD", 32'(stallD), 1);
    check("br.flushE", 32'(flushE), 1);
    check("br.flushD", 32'(flushD), 0);
    cycle("br");

    // Load waiting three cycles on the data memory.
    idle();
    memtoregM = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("mw.stallE", 32'(stallE), 1);
      check("mw.flushW", 32'(flushW), 1);
      cycle("mw");
    end
    dmem_ready = 1;
    #1 check("mw.done", 32'(stallM), 0);
    cycle("mwDone");
    idle();
    check("mw.noErr", 32'(mem_err), 0);
    cycle("mwIdle");

    // Store that never completes: abort after TIMEOUT stall cycles.
    idle();
    memwriteM = 1; dmem_ready = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1 check("to.stallM", 32'(stallM), 1);
      check("to.noErrYet", 32'(mem_err), 0);
      cycle("to");
    end
    #1 check("to.abortStall", 32'(stallF), 0);
    check("to.abortFlushW", 32'(flushW), 0);
    check("to.err", 32'(mem_err), 1);
    cycle("toAbort");
    #1 check("to.restall", 32'(stallM), 1);
    cycle("toRestall");
    dmem_ready = 1;
    cycle("toDone");
    idle();
    check("to.sticky", 32'(mem_err), 1);
    cycle("toIdle");

    // Load-use and memory stall together: memory stall dominates.
    idle();
    memtoregE = 1; rtE = 8; rsD = 8; memtoregM = 1; dmem_ready = 0;
    #1 check("dom.stallF", 32'(stallF), 1);
    check("dom.stallE", 32'(stallE), 1);
    check("dom.stallM", 32'(stallM), 1);
    check("dom.flushW", 32'(flushW), 1);
    check("dom.flushE", 32'(flushE), 0);
    cycle("dom");
    dmem_ready = 1;
    cycle("domLw");
    idle();
    cycle("domIdle");

    // Reset pulsed in the middle of a memory wait.
    idle();
    memwriteM = 1; dmem_ready = 0;
    cycle("rw");
    cycle("rw");
    #2 reset = 1'b0;
    #1 checkAllZero("rwAsync");
    @(posedge clk); #1;
    checkAllZero("rwHeld");
    reset = 1'b1;
    resetModel();
    #1 check("rw.restart", 32'(stallM), 1);
    for (int i = 0; i < TIMEOUT; i++) begin
      cycle("rwRun");
    end
    #1 check("rw.fullTimeout", 32'(mem_err), 1);
    check("rw.abortWindow", 32'(stallM), 0);
    cycle("rwAbort");
    idle();
    cycle("rwIdle");

    // Random traffic; a stalled memory access is held until served.
    for (int n = 0; n < 400; n++) begin
      rsD = 5'($urandom_range(0, 3));
      rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3));
      rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1));
      regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      memtoregE = ($urandom_range(0, 3) == 0);
      branchD   = 1'($urandom_range(0, 1));
      jumpD     = ($urandom_range(0, 3) == 0);
      pcsrcD    = 1'($urandom_range(0, 1));
      if (!mLastMs) begin
        memtoregM = ($urandom_range(0, 3) == 0);
        memwriteM = !memtoregM && ($urandom_range(0, 3) == 0);
      end
      dmem_ready = (memtoregM || memwriteM) ? ($urandom_range(0, 9) < 3) : 1'b1;
      cycle("rand");
    end
    idle();
    #1 check("sat.stall", 32'(stall_cnt), 32'(SAT));
    check("sat.flush", 32'(flush_cnt), 32'(SAT));
    cycle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, 32, width of the performance counters.
REQ-002 SHALL have parameter TIMEOUT, 16, maximum data-memory wait cycles before abort.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rsD, rtD, rsE, rtE  in  5 each  source register numbers in the D and E stages.
REQ-006 SHALL have ports writeregE, writeregM, writeregW  in  5 each  destination register numbers in the E, M and W stages.
REQ-007 SHALL have ports regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM, branchD, jumpD, pcsrcD  in  1 each  stage control bits from the controller.
REQ-008 SHALL have port dmem_ready  in  1  data memory has completed the access presented in M.
REQ-009 SHALL have ports stallF, stallD, stallE, stallM  out  1 each  hold the corresponding pipeline register.
REQ-010 SHALL have ports flushD, flushE, flushW  out  1 each  clear the corresponding pipeline register (insert a bubble).
REQ-011 SHALL have ports forwardAD, forwardBD  out  1 each  select ALUOutM for branch comparison operands.
REQ-012 SHALL have ports forwardAE, forwardBE  out  2 each  E-stage operand select: 00 register file, 01 ResultW, 10 ALUOutM.
REQ-013 SHALL have ports mem_err  out  1, stall_cnt  out  CNT_W, flush_cnt  out  CNT_W: sticky timeout flag and saturating counters.

Function
REQ-014 forwardAE SHALL be 10 if rsE!=0 & regwriteM & rsE==writeregM; else 01 if rsE!=0 & regwriteW & rsE==writeregW; else 00. forwardBE SHALL follow the same rule using rtE. M has priority over W.
REQ-015 forwardAD SHALL be rsD!=0 & regwriteM & rsD==writeregM; forwardBD SHALL follow the same rule using rtD.
REQ-016 lwstall SHALL be memtoregE & (rtE==rsD | rtE==rtD).
REQ-017 branchstall SHALL be branchD & ((regwriteE & (writeregE==rsD | writeregE==rtD)) | (memtoregM & (writeregM==rsD | writeregM==rtD))).
REQ-018 memstall SHALL be (memtoregM | memwriteM) & ~dmem_ready & state!=ABORT.
REQ-019 stallF and stallD SHALL be lwstall | branchstall | memstall. stallE and stallM SHALL be memstall.
REQ-020 flushE SHALL be (lwstall | branchstall) & ~memstall. flushW SHALL be memstall.
REQ-021 flushD SHALL be (pcsrcD | jumpD) & ~stallD.
REQ-022 The memory-wait FSM SHALL have states IDLE, WAIT and ABORT.
REQ-023 FSM transition: IDLE->WAIT when memstall. WAIT->IDLE when dmem_ready. WAIT->ABORT when the wait count reaches TIMEOUT-1 without dmem_ready. ABORT->IDLE unconditionally on the next cycle.
REQ-024 The wait count SHALL clear on entry to WAIT and increment each cycle spent in WAIT.
REQ-025 In ABORT, memstall SHALL be 0, so the pipeline advances one cycle. mem_err SHALL set and remain 1 until reset.
REQ-026 stall_cnt SHALL increment each cycle stallF=1 and saturate at 2^CNT_W-1.
REQ-027 flush_cnt SHALL increment by 1 (not 2) each cycle flushD|flushE=1 and saturate at 2^CNT_W-1.
REQ-028 If lwstall and memstall coincide, memstall dominance SHALL apply: F, D, E and M are held, W is flushed, and E is not flushed.

Reset
REQ-029 While reset=0, the FSM SHALL be IDLE, the wait count 0, mem_err 0, stall_cnt 0 and flush_cnt 0, and all stall, flush and forward outputs SHALL be driven 0.
REQ-030 Reset asserted mid-WAIT SHALL return the FSM to IDLE immediately, and no mem_err SHALL be set.

Structure
REQ-031 Package hazard_pkg SHALL hold the forward-select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the FSM state enum.
REQ-032 Both counters SHALL use one sub-module, sat_counter, parameterized by width, with enable and async active-low reset.

Verification
REQ-033 rsE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardAE=10. Same stimulus with rsE=0 -> forwardAE=00.
REQ-034 memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1 for one cycle. stall_cnt increments by 1.
REQ-035 branchD=1, regwriteE=1, writeregE=rtD=3 -> stallD=1, flushE=1, flushD=0 even with pcsrcD=1.
REQ-036 memtoregM=1, dmem_ready low 3 cycles then high -> stallF..stallM=1 and flushW=1 for 3 cycles, FSM returns to IDLE, mem_err=0.
REQ-037 memwriteM=1, dmem_ready held low with TIMEOUT=4 -> ABORT after 4 stall cycles, stalls drop for one cycle, mem_err=1 and stays 1.
REQ-038 reset pulsed low mid-WAIT -> all outputs 0 asynchronously, counters 0, and after release the FSM restarts from IDLE.
